// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding, lock-loss counter
// width and a small helper used to size the shared cycle counter.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_RELEASE   = 3'd1,
    ST_RUN       = 3'd2,
    ST_ASSERT    = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

  localparam int LOSS_W = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous status bit; cleared by rst_n.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      dout <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: waits for stable PLL lock, releases domain resets in
// order, services soft-reset requests and re-asserts everything on lock loss.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOM     = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  input  logic               soft_req,
  output logic               soft_ack,
  output logic [NUM_DOM-1:0] rst_out,
  output logic               ready,
  output logic [LOSS_W-1:0]  lock_losses
);

  localparam int CNT_W = $clog2(max3(LOCK_CYCLES, GAP_CYCLES, HOLD_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_DOM + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             lock;

  sync_2ff u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (pll_locked),
    .dout (lock)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_WAIT_LOCK;
      cnt         <= '0;
      idx         <= '0;
      rst_out     <= '1;
      ready       <= 1'b0;
      soft_ack    <= 1'b0;
      lock_losses <= '0;
    end else begin
      soft_ack <= 1'b0;
      if (state != ST_WAIT_LOCK && !lock) begin
        // Lock loss overrides everything; a pending soft request is acked so
        // the requester never waits forever.
        state   <= ST_WAIT_LOCK;
        cnt     <= '0;
        idx     <= '0;
        rst_out <= '1;
        ready   <= 1'b0;
        if (state == ST_ASSERT || state == ST_HOLD) soft_ack <= 1'b1;
        if (lock_losses != '1) lock_losses <= lock_losses + 1'b1;
      end else begin
        case (state)
          ST_WAIT_LOCK: begin
            if (!lock) begin
              cnt <= '0;
            end else if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
              state <= ST_RELEASE;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RELEASE: begin
            if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
              cnt <= '0;
              for (int i = 0; i < NUM_DOM; i++)
                if (idx == IDX_W'(i)) rst_out[i] <= 1'b0;
              if (idx == IDX_W'(NUM_DOM - 1)) begin
                idx   <= '0;
                state <= ST_RUN;
                ready <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN: begin
            if (soft_req) begin
              state <= ST_ASSERT;
              idx   <= IDX_W'(NUM_DOM - 1);
              ready <= 1'b0;
            end
          end
          ST_ASSERT: begin
            // Re-assert in reverse release order, one domain per cycle.
            for (int i = 0; i < NUM_DOM; i++)
              if (idx == IDX_W'(i)) rst_out[i] <= 1'b1;
            if (idx == '0) begin
              state <= ST_HOLD;
              cnt   <= '0;
            end else begin
              idx <= idx - 1'b1;
            end
          end
          ST_HOLD: begin
            if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              soft_ack <= 1'b1;
              state    <= ST_WAIT_LOCK;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state   <= ST_WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            rst_out <= '1;
            ready   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timeline-based reference model compared every
// cycle, plus literal timing expectations for the main scenarios.
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int LOCK = 16;
  localparam int GAP  = 8;
  localparam int HOLD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pll_locked = 1'b0;
  logic         soft_req = 1'b0;
  logic         soft_ack;
  logic [N-1:0] rst_out;
  logic         ready;
  logic [7:0]   lock_losses;

  int errors = 0;
  int checks = 0;

  reset_sequencer #(
    .NUM_DOM(N), .LOCK_CYCLES(LOCK), .GAP_CYCLES(GAP), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .soft_req(soft_req),
    .soft_ack(soft_ack), .rst_out(rst_out), .ready(ready), .lock_losses(lock_losses)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 wait-lock, 1 releasing, 2 running, 3 soft reset.
  // Outputs are derived from time spent in the current mode.
  int           m_mode, m_cnt, m_t, m_loss;
  logic         m_p1, m_p2, m_ack, m_ready;
  logic [N-1:0] m_rst;

  always @(posedge clk or negedge rst_n) begin
    logic lk;
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_t = 0; m_loss = 0;
      m_p1 = 0; m_p2 = 0; m_ack = 0;
    end else begin
      lk = m_p2; m_p2 = m_p1; m_p1 = pll_locked;
      m_ack = 0;
      if (m_mode == 0) begin
        if (lk) begin
          m_cnt++;
          if (m_cnt == LOCK) begin m_mode = 1; m_t = 0; end
        end else m_cnt = 0;
      end else if (!lk) begin
        if (m_mode == 3) m_ack = 1;
        m_mode = 0; m_cnt = 0;
        if (m_loss < 255) m_loss++;
      end else if (m_mode == 1) begin
        m_t++;
        if (m_t == GAP * N) m_mode = 2;
      end else if (m_mode == 2) begin
        if (soft_req) begin m_mode = 3; m_t = 0; end
      end else begin
        m_t++;
        if (m_t == N + HOLD) begin m_ack = 1; m_mode = 0; m_cnt = 0; end
      end
    end
    for (int i = 0; i < N; i++) begin
      case (m_mode)
        1:       m_rst[i] = (m_t < GAP * (i + 1));
        2:       m_rst[i] = 1'b0;
        3:       m_rst[i] = (m_t >= N - i);
        default: m_rst[i] = 1'b1;
      endcase
    end
    m_ready = (m_mode == 2);
  end

  always @(negedge clk) begin
    checks++;
    if (rst_out !== m_rst || ready !== m_ready || soft_ack !== m_ack ||
        lock_losses !== 8'(m_loss)) begin
      errors++;
      $display("FAIL model t=%0t got rst=%b rdy=%b ack=%b loss=%0d want rst=%b rdy=%b ack=%b loss=%0d",
               $time, rst_out, ready, soft_ack, lock_losses, m_rst, m_ready, m_ack, m_loss);
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; pll_locked = 1'b1; soft_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n;
    n = 0;
    while (!ready && n < bound) begin step(); n++; end
    if (!ready) begin
      checks++; errors++;
      $display("FAIL %s timeout got ready=0 want ready=1", name);
    end
  endtask

  initial begin
    int base_loss;
    int acks;
    int n;

    // Power-up sequence with fixed release edges.
    do_reset();
    chk("reset_rst_out", rst_out, 3'b111);
    chk("reset_loss", lock_losses, 0);
    for (int e = 1; e <= 42; e++) begin
      step();
      if (e == 25) chk("t1_e25", rst_out, 3'b111);
      if (e == 26) chk("t1_e26", rst_out, 3'b110);
      if (e == 33) chk("t1_e33", rst_out, 3'b110);
      if (e == 34) chk("t1_e34", rst_out, 3'b100);
      if (e == 41) chk("t1_e41_ready", ready, 0);
      if (e == 42) begin chk("t1_e42", rst_out, 3'b000); chk("t1_e42_ready", ready, 1); end
    end

    // Lock glitch while counting restarts the count.
    do_reset();
    for (int e = 1; e <= 39; e++) begin
      step();
      if (e == 12) pll_locked = 1'b0;
      if (e == 13) pll_locked = 1'b1;
      if (e == 38) chk("t2_e38", rst_out, 3'b111);
      if (e == 39) chk("t2_e39", rst_out, 3'b110);
    end
    chk("t2_loss", lock_losses, 0);
    wait_ready("t2_ready", 100);

    // Soft reset handshake.
    soft_req = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (e == 1) begin soft_req = 1'b0; chk("t3_ready_fall", ready, 0); end
      if (e == 2) chk("t3_e2", rst_out, 3'b100);
      if (e == 3) chk("t3_e3", rst_out, 3'b110);
      if (e == 4) chk("t3_e4", rst_out, 3'b111);
      if (e == 7) chk("t3_ack_early", soft_ack, 0);
      if (e == 8) chk("t3_ack", soft_ack, 1);
      if (e == 9) chk("t3_ack_end", soft_ack, 0);
    end
    wait_ready("t3_reseq", 100);

    // Lock loss during HOLD acks once.
    base_loss = lock_losses;
    soft_req = 1'b1;
    acks = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (soft_ack) acks++;
      if (e == 1) soft_req = 1'b0;
      if (e == 4) pll_locked = 1'b0;
      if (e == 7) begin
        chk("t5_ack_on_loss", soft_ack, 1);
        chk("t5_loss_inc", lock_losses, base_loss + 1);
      end
    end
    chk("t5_ack_count", acks, 1);
    pll_locked = 1'b1;
    wait_ready("t5_ready", 100);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      pll_locked = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      soft_req = ($urandom_range(0, 9) == 0);
    end
    soft_req = 1'b0;
    pll_locked = 1'b1;

    // Repeated lock loss saturates the counter.
    do_reset();
    wait_ready("t4_first_ready", 100);
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      repeat (3) step();
      if (k == 0) begin
        chk("t4_rst_all", rst_out, 3'b111);
        chk("t4_ready_low", ready, 0);
        chk("t4_loss1", lock_losses, 1);
      end
      pll_locked = 1'b1;
      wait_ready("t4_ready", 100);
    end
    chk("t4_saturate", lock_losses, 255);

    // Async reset mid-release.
    pll_locked = 1'b0;
    repeat (3) step();
    pll_locked = 1'b1;
    n = 0;
    while (rst_out !== 3'b110 && n < 100) begin step(); n++; end
    chk("t6_reached_release", rst_out, 3'b110);
    rst_n = 1'b0;
    #1;
    chk("t6_async_rst", rst_out, 3'b111);
    chk("t6_async_ready", ready, 0);
    chk("t6_async_loss", lock_losses, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int e = 1; e <= 42; e++) begin
      step();
      if (e == 25) chk("t6_e25", rst_out, 3'b111);
      if (e == 26) chk("t6_e26", rst_out, 3'b110);
      if (e == 42) chk("t6_e42_ready", ready, 1);
    end

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
